// File: rtl/nn_pkg.sv
// Shared network constants and the max_finder scan state type.
package nn_pkg;

  localparam int DATA_WIDTH        = 16;
  localparam int NUM_FINAL_NEURONS = 10;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/max_finder.sv
// Argmax over the final layer: captures all outputs, then compares one element per cycle (signed, lowest index wins ties).
// Latency numInput-1 edges after acceptance; no backpressure, i_valid during a scan is dropped.
// MAX_FINDER_OVERRUN_EN adds a sticky o_overrun flag for i_valid seen mid-scan.
module max_finder
  import nn_pkg::*;
#(
  parameter int numInput   = NUM_FINAL_NEURONS,
  parameter int inputWidth = DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [numInput*inputWidth-1:0]   i_data,
  input  logic                             i_valid,
  output logic [31:0]                      o_data,
  output logic                             o_data_valid,
  output logic                             o_busy
`ifdef MAX_FINDER_OVERRUN_EN
  ,
  output logic                             o_overrun
`endif
);

  localparam int             IW   = $clog2(numInput);
  localparam logic [IW-1:0]  LAST = IW'(numInput - 1);

  state_t                          state_q, state_d;
  logic [numInput*inputWidth-1:0]  buf_q, buf_d;
  logic [IW-1:0]                   count_q, count_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic signed [inputWidth-1:0]    max_q, max_d;
  logic [31:0]                     o_data_q, o_data_d;
  logic                            vld_q, vld_d;
  logic signed [inputWidth-1:0]    cur;
  logic                            gt;

  assign cur = buf_q[int'(count_q)*inputWidth +: inputWidth];
  assign gt  = cur > max_q;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    count_d  = count_q;
    idx_d    = idx_q;
    max_d    = max_q;
    o_data_d = o_data_q;
    vld_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          buf_d   = i_data;
          max_d   = i_data[inputWidth-1:0];
          idx_d   = '0;
          count_d = IW'(1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Strict compare keeps the earliest index on ties.
        if (gt) begin
          max_d = cur;
          idx_d = count_q;
        end
        if (count_q == LAST) begin
          o_data_d = 32'(gt ? count_q : idx_q);
          vld_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      max_q    <= '0;
      o_data_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      max_q    <= max_d;
      o_data_q <= o_data_d;
      vld_q    <= vld_d;
    end
  end

  assign o_data       = o_data_q;
  assign o_data_valid = vld_q;
  assign o_busy       = (state_q == SCAN);

`ifdef MAX_FINDER_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q | (i_valid && (state_q == SCAN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign o_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_max_finder.sv
// Scoreboard bench for max_finder: expected index and result cycle queued at issue, checked by a monitor on o_data_valid.
module tb_max_finder;
  import nn_pkg::*;

  localparam int N = 10;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] i_data;
  logic           i_valid;
  logic [31:0]    o_data;
  logic           o_data_valid;
  logic           o_busy;
`ifdef MAX_FINDER_OVERRUN_EN
  logic           o_overrun;
`endif

  max_finder #(.numInput(N), .inputWidth(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_busy       (o_busy)
`ifdef MAX_FINDER_OVERRUN_EN
    ,
    .o_overrun    (o_overrun)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       e_mon;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [W-1:0] el [N];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: find the maximum signed value, then the first index holding it.
  function automatic int ref_argmax();
    int mx;
    mx = int'($signed(el[0]));
    for (int k = 1; k < N; k++)
      if (int'($signed(el[k])) > mx) mx = int'($signed(el[k]));
    for (int k = 0; k < N; k++)
      if (int'($signed(el[k])) == mx) return k;
    return -1;
  endfunction

  function automatic logic [N*W-1:0] pack_el();
    logic [N*W-1:0] p;
    for (int k = 0; k < N; k++) p[k*W +: W] = el[k];
    return p;
  endfunction

  // Monitor: every pulse must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    if (o_data_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got o_data_valid=1 with o_data=%0d, required no pulse (t=%0t)", o_data, $time);
      end else begin
        e_mon = sb.pop_front();
        check("o_data", o_data, e_mon.idx);
        check("latency_cycle", cyc, e_mon.cyc);
        check("busy_at_pulse", o_busy, 0);
      end
    end
  end

  // Called at a negedge; accepting edge is the next posedge. exp<0 means the pulse is not expected.
  task automatic drive(input int exp);
    i_data  = pack_el();
    i_valid = 1'b1;
    if (exp >= 0) sb.push_back('{exp, cyc + 10});
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = {5{$urandom()}};
  endtask

  task automatic send(input int exp);
    @(negedge clk);
    drive(exp);
  endtask

  task automatic wait_done();
    #1;
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic rand_el(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0:       el[k] = W'($urandom());
        1:       el[k] = W'($urandom_range(0, 3));
        default: el[k] = W'(16'h8000 + $urandom_range(0, 3));
      endcase
    end
  endtask

  int busy_cnt;
  int exp_a;

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_o_data", o_data, 0);
    check("rst_o_data_valid", o_data_valid, 0);
    check("rst_o_busy", o_busy, 0);
`ifdef MAX_FINDER_OVERRUN_EN
    check("rst_o_overrun", o_overrun, 0);
`endif
    rst = 1'b0;

    // Basic scan with busy-length measurement
    el = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd0, 16'd2, 16'd7, 16'd8, 16'd4, 16'd6};
    send(2);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!o_busy) break;
      busy_cnt++;
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, 9);
    wait_done();
    repeat (3) @(negedge clk);
    check("o_data_hold", o_data, 2);
    check("valid_low_after", o_data_valid, 0);

    // Ties and signed ordering
    for (int k = 0; k < N; k++) el[k] = 16'h0100;
    send(0);
    wait_done();
    el = '{16'd1, 16'd8, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send(1);
    wait_done();
    for (int k = 0; k < N; k++) el[k] = 16'h8000;
    el[7] = 16'hFFFF;
    send(7);
    wait_done();

    // Back-to-back: new request in the pulse cycle
    rand_el(0);
    send(ref_argmax());
    for (int i = 0; i < 40; i++) begin
      if (o_data_valid) break;
      @(negedge clk);
    end
    check("b2b_pulse_seen", o_data_valid, 1);
    for (int k = 0; k < N; k++) el[k] = 16'd0;
    el[9] = 16'd5;
    drive(9);
    wait_done();

    // Overrun: second request three cycles into a scan is dropped
    rand_el(0);
    exp_a = ref_argmax();
    send(exp_a);
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) el[k] = 16'd0;
    el[(exp_a + 1) % N] = 16'h7FFF;
    drive(-1);
    wait_done();
    repeat (15) @(negedge clk);
    check("overrun_result_kept", o_data, exp_a);
`ifdef MAX_FINDER_OVERRUN_EN
    check("overrun_flag_set", o_overrun, 1);
`endif

    // Mid-scan reset aborts without a pulse
    rand_el(0);
    send(-1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_o_busy", o_busy, 0);
    check("abort_o_data", o_data, 0);
    check("abort_o_data_valid", o_data_valid, 0);
`ifdef MAX_FINDER_OVERRUN_EN
    check("abort_overrun_clear", o_overrun, 0);
`endif
    repeat (15) @(negedge clk);
    el = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6, 16'd5, 16'd3};
    send(5);
    wait_done();

    // Randomized traffic, including tie-heavy and all-negative sets
    for (int t = 0; t < 30; t++) begin
      rand_el($urandom_range(0, 2));
      send(ref_argmax());
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
